cdb_arbiter: RTL and testbench

Collects completed results from the functional units and drives the single Common Data Bus (CDB) consumed by the reorder buffer (`rob_cdb_in`) and the reservation stations (`rs_cdb_in` / `rs_cdb_tag` / `rs_cdb_valid`). Each functional unit (FU) gets a one-entry holding buffer with a valid/ready handshake. A rotating-priority arbiter grants one buffered result per cycle, and the CDB outputs are registered. A ROB flush drops every in-flight result.

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 48 ++++
 rtl/cdb_arbiter.sv | 154 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// Module : cdb_arbiter_pkg
// Brief  : Shared widths and the CDB broadcast packet for the CDB arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

  localparam int ROB_TAG_BITS   = 6;
  localparam int NUM_FU_DEFAULT = 4;
  localparam int XLEN           = 32;

  // ROB and reservation-station CDB inputs are driven from these fields.
  typedef struct packed {
    logic                    valid;
    logic [ROB_TAG_BITS-1:0] tag;
    logic [XLEN-1:0]         value;
  } cdb_packet_t;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational rotating-priority arbiter. Scans from i_ptr upward
//          (modulo WIDTH) and grants the first requester, one-hot.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [WIDTH-1:0] o_grant,
  output logic [PTR_W-1:0] o_grant_idx,
  output logic             o_grant_any
);

  localparam logic [PTR_W:0] C_WIDTH = (PTR_W+1)'(WIDTH);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // One extra bit on the sum so non-power-of-two widths wrap correctly.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= C_WIDTH) begin
        w_sum = w_sum - C_WIDTH;
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!o_grant_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_grant_any    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Brief  : One-entry result buffer per FU, round-robin grant onto a single
//          registered Common Data Bus, flushed by rob_clear.
//          Macro CDB_BYPASS_EN: an empty-slot FU result may win directly.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEFAULT,
  parameter int TAG_W  = ROB_TAG_BITS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]       fu_tag,
  input  logic [NUM_FU*XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic                          rob_clear,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [XLEN-1:0]               cdb_value,
  output logic [$clog2(NUM_FU+1)-1:0]   cdb_pending
);

  localparam int                 C_PTR_W = $clog2(NUM_FU);
  localparam int                 C_CNT_W = $clog2(NUM_FU+1);
  localparam logic [C_PTR_W-1:0] C_LAST  = C_PTR_W'(NUM_FU-1);

  logic [NUM_FU-1:0]  buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]   buf_tag_q   [NUM_FU];
  logic [TAG_W-1:0]   buf_tag_d   [NUM_FU];
  logic [XLEN-1:0]    buf_value_q [NUM_FU];
  logic [XLEN-1:0]    buf_value_d [NUM_FU];
  logic [C_PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]    cdb_value_q, cdb_value_d;

  logic [TAG_W-1:0]   w_fu_tag   [NUM_FU];
  logic [XLEN-1:0]    w_fu_value [NUM_FU];
  logic [NUM_FU-1:0]  w_cand;
  logic [NUM_FU-1:0]  w_grant;
  logic [NUM_FU-1:0]  w_bypass_hit;
  logic [NUM_FU-1:0]  w_accept;
  logic [C_PTR_W-1:0] w_win;
  logic               w_any;
  logic [TAG_W-1:0]   w_win_tag;
  logic [XLEN-1:0]    w_win_value;
  logic [C_CNT_W-1:0] w_count;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_unpack
      assign w_fu_tag[gi]   = fu_tag[gi*TAG_W +: TAG_W];
      assign w_fu_value[gi] = fu_value[gi*XLEN +: XLEN];
    end
  endgenerate

`ifdef CDB_BYPASS_EN
  assign w_cand = rob_clear ? '0 : (buf_valid_q | fu_valid);
`else
  assign w_cand = rob_clear ? '0 : buf_valid_q;
`endif

  rr_arbiter #(
    .WIDTH (NUM_FU),
    .PTR_W (C_PTR_W)
  ) u_rr_arbiter (
    .i_req       (w_cand),
    .i_ptr       (rr_ptr_q),
    .o_grant     (w_grant),
    .o_grant_idx (w_win),
    .o_grant_any (w_any)
  );

  // A granted slot may be refilled on the same edge it drains.
  assign fu_ready     = {NUM_FU{!rob_clear}} & (~buf_valid_q | w_grant);
  assign w_accept     = fu_valid & fu_ready;
  assign w_bypass_hit = w_grant & ~buf_valid_q;

  assign w_win_tag   = buf_valid_q[w_win] ? buf_tag_q[w_win]   : w_fu_tag[w_win];
  assign w_win_value = buf_valid_q[w_win] ? buf_value_q[w_win] : w_fu_value[w_win];

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_value_d = buf_value_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    if (rob_clear) begin
      buf_valid_d = '0;
      rr_ptr_d    = '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_accept[i] && !w_bypass_hit[i]) begin
          buf_valid_d[i] = 1'b1;
          buf_tag_d[i]   = w_fu_tag[i];
          buf_value_d[i] = w_fu_value[i];
        end else if (w_grant[i]) begin
          buf_valid_d[i] = 1'b0;
        end
      end
      if (w_any) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = w_win_tag;
        cdb_value_d = w_win_value;
        rr_ptr_d    = (w_win == C_LAST) ? '0 : w_win + C_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        buf_tag_q[i]   <= '0;
        buf_value_q[i] <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_value_q <= buf_value_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_count = w_count + C_CNT_W'(buf_valid_q[i]);
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_pending = w_count;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Brief  : Directed bench for cdb_arbiter with a cycle-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TW = ROB_TAG_BITS;
`ifdef CDB_BYPASS_EN
  localparam bit BYP     = 1'b1;
  localparam int EXP_LAT = 1;
`else
  localparam bit BYP     = 1'b0;
  localparam int EXP_LAT = 2;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    fu_valid;
  logic [N*TW-1:0] fu_tag;
  logic [N*32-1:0] fu_value;
  logic [N-1:0]    fu_ready;
  logic            rob_clear;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [31:0]     cdb_value;
  logic [2:0]      cdb_pending;

  cdb_arbiter #(.NUM_FU(N), .TAG_W(TW)) dut (
    .clock       (clock),
    .reset       (reset),
    .fu_valid    (fu_valid),
    .fu_tag      (fu_tag),
    .fu_value    (fu_value),
    .fu_ready    (fu_ready),
    .rob_clear   (rob_clear),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .cdb_pending (cdb_pending)
  );

  always #5 clock = ~clock;

  // FU-side offers, held until the model says they transferred
  bit          pv   [N];
  int          ptag [N];
  logic [31:0] pval [N];
  bit          clr;

  // reference model: occupied slots, pointer, broadcast register
  bit          mb_v [N];
  int          mb_t [N];
  logic [31:0] mb_d [N];
  int          m_ptr;
  bit          m_cv;
  int          m_ct;
  logic [31:0] m_cd;
  bit          m_xfer [N];

  int acc_cnt [64];
  int brd_cnt [64];
  int n_chk, n_pass;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fu_valid[i]           = pv[i];
      fu_tag[i*TW +: TW]    = TW'(ptag[i]);
      fu_value[i*32 +: 32]  = pval[i];
    end
    rob_clear = clr;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mb_v[i] = 0; mb_t[i] = 0; mb_d[i] = '0; pv[i] = 0; m_xfer[i] = 0;
      ptag[i] = 0; pval[i] = '0;
    end
    m_ptr = 0; m_cv = 0; m_ct = 0; m_cd = '0;
  endtask

  // One clock: check ready before the edge, advance the model, check after.
  task automatic step();
    int          win;
    bit          cand;
    logic [N-1:0] rdy;
    int          pc;
    drive();
    #1;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      cand = !clr && (mb_v[j] || (BYP && pv[j]));
      if (win < 0 && cand) win = j;
    end
    for (int i = 0; i < N; i++) rdy[i] = !clr && (!mb_v[i] || win == i);
    chk("fu_ready", longint'(fu_ready), longint'(rdy));
    if (clr) begin
      for (int i = 0; i < N; i++) begin mb_v[i] = 0; m_xfer[i] = 0; end
      m_cv = 0; m_ptr = 0;
    end else begin
      if (win >= 0) begin
        m_cv = 1;
        m_ct = mb_v[win] ? mb_t[win] : ptag[win];
        m_cd = mb_v[win] ? mb_d[win] : pval[win];
        m_ptr = (win + 1) % N;
      end else begin
        m_cv = 0;
      end
      for (int i = 0; i < N; i++) begin
        m_xfer[i] = pv[i] && rdy[i];
        if (m_xfer[i] && !(win == i && !mb_v[i])) begin
          mb_v[i] = 1; mb_t[i] = ptag[i]; mb_d[i] = pval[i];
        end else if (win == i) begin
          mb_v[i] = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    pc = 0;
    for (int i = 0; i < N; i++) pc += int'(mb_v[i]);
    chk("cdb_valid",   longint'(cdb_valid),   longint'(m_cv));
    chk("cdb_tag",     longint'(cdb_tag),     longint'(m_ct));
    chk("cdb_value",   longint'(cdb_value),   longint'(m_cd));
    chk("cdb_pending", longint'(cdb_pending), longint'(pc));
    if (cdb_valid) brd_cnt[cdb_tag]++;
    for (int i = 0; i < N; i++) begin
      if (m_xfer[i]) begin acc_cnt[ptag[i]]++; pv[i] = 0; end
    end
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, vcyc, got_tag, s_first, s_last, nt, bad, busy, n9, viol, first_tag;
    longint got_val;
    int seq [$];
    bit acc9, seen9, prev_fu0;
    n_chk = 0; n_pass = 0; clr = 0;
    for (int t = 0; t < 64; t++) begin acc_cnt[t] = 0; brd_cnt[t] = 0; end
    model_reset();
    drive();
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_cdb_valid",   longint'(cdb_valid),   0);
    chk("rst_cdb_tag",     longint'(cdb_tag),     0);
    chk("rst_cdb_value",   longint'(cdb_value),   0);
    chk("rst_cdb_pending", longint'(cdb_pending), 0);
    chk("rst_fu_ready",    longint'(fu_ready),    'hF);

    // 1: single result
    pv[0] = 1; ptag[0] = 3; pval[0] = 32'h12345678;
    lat = -1; vcyc = 0; got_tag = -1; got_val = -1;
    for (int s = 1; s <= 6; s++) begin
      step();
      if (cdb_valid) begin
        if (lat < 0) begin lat = s; got_tag = int'(cdb_tag); got_val = longint'(cdb_value); end
        vcyc++;
      end
    end
    chk("t1_latency", lat, EXP_LAT);
    chk("t1_valid_cycles", vcyc, 1);
    chk("t1_tag", got_tag, 3);
    chk("t1_value", got_val, 'h12345678);

    // 2: contention, pointer reset to 0 by a flush
    clr = 1; step(); clr = 0;
    for (int i = 0; i < N; i++) begin pv[i] = 1; ptag[i] = i + 1; pval[i] = 32'hA0 + i; end
    step();
`ifndef CDB_BYPASS_EN
    chk("t2_pending_full", longint'(cdb_pending), 4);
`endif
    s_first = -1; s_last = -1;
    for (int s = 0; s < 7; s++) begin
      if (s > 0) step();
`ifndef CDB_BYPASS_EN
      if (s >= 1 && s <= 4) chk("t2_pending_drain", longint'(cdb_pending), 4 - s);
`endif
      if (cdb_valid) begin
        seq.push_back(int'(cdb_tag));
        if (s_first < 0) s_first = s;
        s_last = s;
      end
    end
    chk("t2_count", seq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_order", (seq.size() > i) ? seq[i] : -1, i + 1);
    chk("t2_no_bubble", s_last - s_first, 3);

    // 3: fairness, FU0 streams while FU2 offers tag 9 once
    clr = 1; step(); clr = 0;
    nt = 5; n9 = 0; viol = 0; acc9 = 0; seen9 = 0; prev_fu0 = 0;
    for (int s = 0; s < 10; s++) begin
      if (!pv[0] && nt < 9) begin pv[0] = 1; ptag[0] = nt; pval[0] = 32'h500 + nt; nt++; end
      if (s == 1) begin pv[2] = 1; ptag[2] = 9; pval[2] = 32'h999; end
      step();
      if (m_xfer[2]) acc9 = 1;
      if (acc9 && !seen9 && cdb_valid) begin
        n9++;
        if (cdb_tag == 6'd9) seen9 = 1;
      end
      if (acc9 && !seen9 && cdb_valid && cdb_tag != 6'd9 && prev_fu0) viol++;
      prev_fu0 = cdb_valid && cdb_tag != 6'd9;
    end
    chk("t3_tag9_seen", longint'(seen9), 1);
    chk("t3_tag9_within_2", longint'(n9 >= 1 && n9 <= 2), 1);
    chk("t3_fu0_repeat", viol, 0);

    // 4: back-pressure and random traffic against the scoreboard
    clr = 1; step(); clr = 0;
    for (int t = 0; t < 64; t++) begin acc_cnt[t] = 0; brd_cnt[t] = 0; end
    pv[0] = 1; ptag[0] = 2; pval[0] = 32'h22;
    pv[1] = 1; ptag[1] = 7; pval[1] = 32'h77;
    step();
    pv[1] = 1; ptag[1] = 8; pval[1] = 32'h88;
    drive(); #1;
`ifndef CDB_BYPASS_EN
    chk("t4_ready1_blocked", longint'(fu_ready[1]), 0);
`endif
    step();
    drive(); #1;
`ifndef CDB_BYPASS_EN
    chk("t4_ready1_granted", longint'(fu_ready[1]), 1);
`endif
    step();
    nt = 16;
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1 && nt < 64) begin
          pv[i] = 1; ptag[i] = nt; pval[i] = $urandom; nt++;
        end
      end
      step();
    end
    for (int s = 0; s < 24; s++) step();
    busy = 0;
    for (int i = 0; i < N; i++) busy += int'(pv[i]) + int'(mb_v[i]);
    chk("t4_drained", busy, 0);
    bad = 0;
    for (int t = 0; t < 64; t++) if (acc_cnt[t] != brd_cnt[t]) bad++;
    chk("t4_scoreboard_bad_tags", bad, 0);

    // 5: flush with three buffers full and FU3 offering
    for (int i = 0; i < 3; i++) begin pv[i] = 1; ptag[i] = 20 + i; pval[i] = 32'h200 + i; end
    step();
`ifndef CDB_BYPASS_EN
    chk("t5_pending_three", longint'(cdb_pending), 3);
`endif
    clr = 1; pv[3] = 1; ptag[3] = 23; pval[3] = 32'h203;
    drive(); #1;
    chk("t5_ready_zero", longint'(fu_ready), 0);
    step();
    chk("t5_valid_after", longint'(cdb_valid), 0);
    chk("t5_pending_after", longint'(cdb_pending), 0);
    clr = 0; pv[3] = 0;
    vcyc = 0;
    for (int s = 0; s < 4; s++) begin
      step();
      if (cdb_valid) vcyc++;
    end
    chk("t5_bcasts_after_flush", vcyc, 0);

    // 6: asynchronous reset while broadcasting
    for (int i = 0; i < N; i++) begin pv[i] = 1; ptag[i] = 40 + i; pval[i] = 32'h400 + i; end
    step();
    step();
    chk("t6_valid_before", longint'(cdb_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid_rst", longint'(cdb_valid), 0);
    chk("t6_tag_rst",   longint'(cdb_tag),   0);
    chk("t6_value_rst", longint'(cdb_value), 0);
    chk("t6_pending_rst", longint'(cdb_pending), 0);
    model_reset();
    drive();
    #3 reset = 1'b0;
    step();
    pv[3] = 1; ptag[3] = 50; pval[3] = 32'h500;
    pv[0] = 1; ptag[0] = 51; pval[0] = 32'h501;
    first_tag = -1;
    for (int s = 0; s < 6; s++) begin
      step();
      if (cdb_valid && first_tag < 0) first_tag = int'(cdb_tag);
    end
    chk("t6_first_grant_fu0", first_tag, 51);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
